if_id_queue: RTL

- Instruction queue that sits directly downstream of the fetch stage and feeds the decode stage.
- Captures {pc_adder_out, instruction} pairs from fetch in a small first-in-first-out (FIFO) queue. The head entry is presented to decode as soon as it is written (first-word fall-through, FWFT).
- Decouples fetch from decode stalls: `full` drives fetch's freeze. Taken branches flush the queue.

---
 rtl/if_id_queue_pkg.sv | 33 +++
 rtl/if_id_queue_mem.sv | 31 +++
 rtl/if_id_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared constants and types for the fetch/decode instruction queue.
// Word width and NOP encoding are common to the fetch and decode stages.
package if_id_queue_pkg;

  localparam int unsigned WordW        = 32;
  localparam int unsigned DefaultDepth = 4;
  localparam logic [WordW-1:0] NopInstr = 32'h0000_0000;

  typedef enum logic [2:0] {
    OpIdle,
    OpPush,
    OpPop,
    OpPushPop,
    OpFlush
  } q_op_e;

  // Flush dominates; the push/pop qualifiers are already gated by flush upstream.
  function automatic q_op_e decode_op(input logic flush, input logic push, input logic pop);
    q_op_e op;
    if (flush) begin
      op = OpFlush;
    end else begin
      unique case ({push, pop})
        2'b10:   op = OpPush;
        2'b01:   op = OpPop;
        2'b11:   op = OpPushPop;
        default: op = OpIdle;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the instruction queue: synchronous write, asynchronous read.
// Synchronous active-low reset clears every entry.
module if_id_queue_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// First-word fall-through queue between fetch and decode; full freezes fetch,
// a taken branch (flush) empties the queue and drops the same-cycle push.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned WIDTH = WordW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_pc,
  input  logic [WIDTH-1:0] push_instr,
  output logic             full,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr,
  output logic [PTR_W:0]   count,
  output logic             overflow_err
);

  localparam int unsigned CntW = PTR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               push, pop;
  q_op_e              op;
  logic [2*WIDTH-1:0] head_data;

  // full depends only on the count register, never on pop_ready.
  assign full      = (count_q == CntW'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = push_valid & ~full & ~flush;
  assign pop  = out_valid & pop_ready & ~flush;
  assign op   = decode_op(flush, push, pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_valid & full & ~flush);
    unique case (op)
      OpFlush: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      OpPush: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CntW'(1);
      end
      OpPop: begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q - CntW'(1);
      end
      OpPushPop: begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  if_id_queue_mem #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .DATA_W (2 * WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({push_pc, push_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  // Empty queue presents a zero PC and a NOP bubble to decode.
  assign out_pc       = out_valid ? head_data[2*WIDTH-1:WIDTH] : '0;
  assign out_instr    = out_valid ? head_data[WIDTH-1:0] : WIDTH'(NopInstr);
  assign count        = count_q;
  assign overflow_err = overflow_q;

endmodule
